// File: rtl/sdram_axi_slave_bridge_pkg.sv
// Shared types and the beat-address helper for the AXI4 slave bridge in front of sdram_axi_core.
// Only 32-bit beats are supported, so each address step is 4 bytes.
package sdram_axi_slave_bridge_pkg;

  localparam int TAG_ID_W = 16;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } bridge_state_t;

  typedef struct packed {
    logic                is_wr;
    logic                last;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] data;
    logic        err;
  } resp_t;

  // A WRAP block is (len+1)*4 bytes, so its offset mask is len*4+3.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input burst_t burst,
                                            input logic [7:0] len);
    logic [31:0] mask;
    logic [31:0] inc;
    mask = {22'd0, len, 2'b11};
    inc  = addr + 32'd4;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

endpackage

// File: rtl/sdram_axi_slave_bridge_if.sv
// AXI4 slave channels plus the sdram_axi_core inport request/ack channel.
// slave = the bridge's view, master = the view of whoever drives AXI and models the core.
interface sdram_axi_slave_bridge_if #(parameter int ID_W = 4);
  logic            axi_awvalid, axi_awready;
  logic [31:0]     axi_awaddr;
  logic [ID_W-1:0] axi_awid;
  logic [7:0]      axi_awlen;
  logic [1:0]      axi_awburst;
  logic            axi_wvalid, axi_wready;
  logic [31:0]     axi_wdata;
  logic [3:0]      axi_wstrb;
  logic            axi_wlast;
  logic            axi_bvalid, axi_bready;
  logic [ID_W-1:0] axi_bid;
  logic [1:0]      axi_bresp;
  logic            axi_arvalid, axi_arready;
  logic [31:0]     axi_araddr;
  logic [ID_W-1:0] axi_arid;
  logic [7:0]      axi_arlen;
  logic [1:0]      axi_arburst;
  logic            axi_rvalid, axi_rready;
  logic [31:0]     axi_rdata;
  logic [ID_W-1:0] axi_rid;
  logic [1:0]      axi_rresp;
  logic            axi_rlast;
  logic [3:0]      inport_wr;
  logic            inport_rd;
  logic [7:0]      inport_len;
  logic [31:0]     inport_addr, inport_write_data;
  logic            inport_accept, inport_ack, inport_error;
  logic [31:0]     inport_read_data;

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awburst,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
    input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arburst, axi_rready,
    input  inport_accept, inport_ack, inport_error, inport_read_data,
    output axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
    output axi_arready, axi_rvalid, axi_rdata, axi_rid, axi_rresp, axi_rlast,
    output inport_wr, inport_rd, inport_len, inport_addr, inport_write_data
  );

  modport master (
    output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awburst,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
    output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arburst, axi_rready,
    output inport_accept, inport_ack, inport_error, inport_read_data,
    input  axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rid, axi_rresp, axi_rlast,
    input  inport_wr, inport_rd, inport_len, inport_addr, inport_write_data
  );
endinterface

// File: rtl/sdram_axi_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head is read straight from storage.
// Pushes when full and pops when empty are dropped; push+pop together keeps the count.
module sdram_axi_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full_o     = (count_o == CW'(DEPTH));
  assign empty_o    = (count_o == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat_i;
  end
endmodule

// File: rtl/sdram_axi_slave_bridge.sv
// AXI4 slave front-end: splits bursts into per-beat inport requests and rebuilds R/B from in-order acks.
// R/B valid 1 cycle after ack; new beats stall once OUTSTANDING beats are issued but not retired on AXI.
module sdram_axi_slave_bridge
  import sdram_axi_slave_bridge_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int OUTSTANDING = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  sdram_axi_slave_bridge_if.slave bus
);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = CW + 1;

  bridge_state_t   state_q, state_d;
  logic            last_wr_q, sticky_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;
  logic [7:0]      len_q, cnt_q;
  burst_t          burst_q;

  logic            grant_wr, grant_rd, aw_hs, ar_hs, room, beat_fire, last_beat;
  tag_t            tag_in, tag_head;
  resp_t           resp_in, resp_head;
  logic [CW-1:0]   tag_cnt, resp_cnt;
  logic            tag_full, tag_empty, resp_full, resp_empty, tag_pop, resp_pop;
  logic            head_mid, head_b, head_r;

  assign grant_wr  = bus.axi_awvalid && (!bus.axi_arvalid || !last_wr_q);
  assign grant_rd  = bus.axi_arvalid && (!bus.axi_awvalid || last_wr_q);
  assign aw_hs     = bus.axi_awvalid && bus.axi_awready;
  assign ar_hs     = bus.axi_arvalid && bus.axi_arready;
  assign room      = ({1'b0, tag_cnt} + {1'b0, resp_cnt}) < SW'(OUTSTANDING);
  assign last_beat = (cnt_q == 8'd0);
  assign beat_fire = room && bus.inport_accept &&
                     ((state_q == ST_WRITE && bus.axi_wvalid) || state_q == ST_READ);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:           if (aw_hs) state_d = ST_WRITE; else if (ar_hs) state_d = ST_READ;
      ST_WRITE, ST_READ: if (beat_fire && last_beat) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Address readies are combinational, so hold them low while reset is asserted.
  always_comb begin
    bus.axi_awready = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.inport_wr   = 4'b0000;
    bus.inport_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.axi_awready = rst_i && grant_wr;
        bus.axi_arready = rst_i && grant_rd;
      end
      ST_WRITE: begin
        bus.inport_wr  = (bus.axi_wvalid && room) ? bus.axi_wstrb : 4'b0000;
        bus.axi_wready = room && bus.inport_accept;
      end
      ST_READ: bus.inport_rd = room;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_wr_q <= 1'b0;
      sticky_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= BURST_FIXED;
    end else begin
      if (aw_hs) begin
        last_wr_q <= 1'b1;
        id_q      <= bus.axi_awid;
        addr_q    <= bus.axi_awaddr;
        len_q     <= bus.axi_awlen;
        cnt_q     <= bus.axi_awlen;
        burst_q   <= burst_t'(bus.axi_awburst);
      end else if (ar_hs) begin
        last_wr_q <= 1'b0;
        id_q      <= bus.axi_arid;
        addr_q    <= bus.axi_araddr;
        len_q     <= bus.axi_arlen;
        cnt_q     <= bus.axi_arlen;
        burst_q   <= burst_t'(bus.axi_arburst);
      end else if (beat_fire) begin
        addr_q <= next_addr(addr_q, burst_q, len_q);
        cnt_q  <= cnt_q - 8'd1;
      end
      if (resp_pop && resp_head.tag.is_wr)
        sticky_q <= head_b ? 1'b0 : (sticky_q | resp_head.err);
    end
  end

  always_comb begin
    tag_in                = '0;
    tag_in.is_wr          = (state_q == ST_WRITE);
    tag_in.last           = last_beat;
    tag_in.id[ID_W-1:0]   = id_q;
    resp_in.tag           = tag_head;
    resp_in.data          = bus.inport_read_data;
    resp_in.err           = bus.inport_error;
  end

  assign tag_pop = bus.inport_ack && !tag_empty;

  sdram_axi_sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(beat_fire), .push_dat_i(tag_in), .pop_i(tag_pop),
    .head_dat_o(tag_head), .count_o(tag_cnt), .full_o(tag_full), .empty_o(tag_empty)
  );

  sdram_axi_sync_fifo #(.WIDTH($bits(resp_t)), .DEPTH(OUTSTANDING)) u_resp_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tag_pop), .push_dat_i(resp_in), .pop_i(resp_pop),
    .head_dat_o(resp_head), .count_o(resp_cnt), .full_o(resp_full), .empty_o(resp_empty)
  );

  // Non-final write beats only fold their error into the sticky flag; the last one produces B.
  assign head_mid = !resp_empty && resp_head.tag.is_wr && !resp_head.tag.last;
  assign head_b   = !resp_empty && resp_head.tag.is_wr && resp_head.tag.last;
  assign head_r   = !resp_empty && !resp_head.tag.is_wr;
  assign resp_pop = head_mid || (head_b && bus.axi_bready) || (head_r && bus.axi_rready);

  assign bus.axi_bvalid = head_b;
  assign bus.axi_bid    = head_b ? resp_head.tag.id[ID_W-1:0] : '0;
  assign bus.axi_bresp  = (head_b && (sticky_q || resp_head.err)) ? RESP_SLVERR : RESP_OKAY;
  assign bus.axi_rvalid = head_r;
  assign bus.axi_rdata  = head_r ? resp_head.data : 32'd0;
  assign bus.axi_rid    = head_r ? resp_head.tag.id[ID_W-1:0] : '0;
  assign bus.axi_rresp  = (head_r && resp_head.err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.axi_rlast  = head_r && resp_head.tag.last;

  assign bus.inport_len        = len_q;
  assign bus.inport_addr       = addr_q;
  assign bus.inport_write_data = (state_q == ST_WRITE) ? bus.axi_wdata : 32'd0;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.axi_wlast, tag_full, resp_full, resp_head.tag.id};

  ack_needs_tag: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(bus.inport_ack && tag_empty));
endmodule
